// File: rtl/motor_pkg.sv
// Shared definitions for the encoder emulator: parameter defaults, FSM state type,
// and the position-to-quadrature mapping.
package motor_pkg;

  localparam int COUNTS_PER_REV_DEFAULT = 8192;
  localparam int MIN_PERIOD_DEFAULT     = 4;
  localparam int PERIOD_W               = 16;
  localparam int MAG_W                  = PERIOD_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } emu_state_t;

  // Returns {A, B}. Walking the position upward gives 00,10,11,01, so A leads B.
  function automatic logic [1:0] quad_map(input logic [1:0] p);
    return {p[1] ^ p[0], p[1]};
  endfunction

endpackage

// File: rtl/quadrature_encoder_emulator_if.sv
// Command and encoder-output bundle of the quadrature encoder emulator.
interface quadrature_encoder_emulator_if #(
  parameter int POS_W = 13
);
  logic                    enable;
  logic signed [15:0]      tick_period;
  logic                    load;
  logic        [POS_W-1:0] load_position;
  logic                    encoder_a;
  logic                    encoder_b;
  logic                    index;
  logic        [POS_W-1:0] position;
  logic                    tick;

  modport master (
    output enable, tick_period, load, load_position,
    input  encoder_a, encoder_b, index, position, tick
  );

  modport slave (
    input  enable, tick_period, load, load_position,
    output encoder_a, encoder_b, index, position, tick
  );
endinterface

// File: rtl/quadrature_step_timer.sv
// Step timer: latches and clamps the period magnitude and direction, counts clocks,
// and flags the cycle on which the next count step is due.
module quadrature_step_timer
  import motor_pkg::*;
#(
  parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [PERIOD_W-1:0] tick_period,
  input  logic                       latch,
  input  logic                       run,
  input  logic                       clear,
  output logic                       step,
  output logic                       dir_reverse
);

  localparam logic [MAG_W-1:0] MIN_MAG = MAG_W'(MIN_PERIOD);

  logic [MAG_W-1:0] period_ext;
  logic [MAG_W-1:0] mag_raw;
  logic [MAG_W-1:0] mag_clamped;
  logic [MAG_W-1:0] mag_reg;
  logic [MAG_W-1:0] cnt_reg;
  logic             dir_reg;

  // One extra bit so that -32768 has a representable magnitude.
  assign period_ext  = {tick_period[PERIOD_W-1], tick_period};
  assign mag_raw     = period_ext[MAG_W-1] ? (~period_ext + 1'b1) : period_ext;
  assign mag_clamped = (mag_raw < MIN_MAG) ? MIN_MAG : mag_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_reg <= MIN_MAG;
      dir_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      if (latch) begin
        mag_reg <= mag_clamped;
        dir_reg <= tick_period[PERIOD_W-1];
      end
      if (latch || clear || !run) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign step        = (cnt_reg == mag_reg - 1'b1);
  assign dir_reverse = dir_reg;

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature encoder emulator: steps a position at a commanded signed period and
// drives registered A/B/index/tick. Index compare is built only with ENCODER_EMU_INDEX_EN.
module quadrature_encoder_emulator
  import motor_pkg::*;
#(
  parameter int COUNTS_PER_REV = COUNTS_PER_REV_DEFAULT,
  parameter int MIN_PERIOD     = MIN_PERIOD_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  quadrature_encoder_emulator_if.slave  bus
);

  localparam int               POS_W    = $clog2(COUNTS_PER_REV);
  localparam int               POS_W1   = POS_W + 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(COUNTS_PER_REV - 1);
  localparam logic [POS_W:0]   CPR_EXT  = POS_W1'(COUNTS_PER_REV);

  emu_state_t       state_reg, state_next;
  logic [POS_W-1:0] pos_reg, pos_next, pos_inc, pos_dec;
  logic             a_reg, b_reg, tick_reg;
  logic             step_due, dir_reverse;
  logic             step_fire, timer_latch, timer_run;
  logic             load_ok, go;

  quadrature_step_timer #(
    .MIN_PERIOD (MIN_PERIOD)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .tick_period (bus.tick_period),
    .latch       (timer_latch),
    .run         (timer_run),
    .clear       (load_ok),
    .step        (step_due),
    .dir_reverse (dir_reverse)
  );

  assign pos_inc = (pos_reg == LAST_POS) ? '0 : pos_reg + 1'b1;
  assign pos_dec = (pos_reg == '0) ? LAST_POS : pos_reg - 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pos_next    = pos_reg;
    step_fire   = 1'b0;
    timer_latch = 1'b0;
    timer_run   = 1'b0;
    load_ok     = bus.load && ({1'b0, bus.load_position} < CPR_EXT);
    go          = bus.enable && (bus.tick_period != '0);
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next  = RUN;
          timer_latch = 1'b1;
        end
      end
      RUN: begin
        // Dropping enable abandons the partial interval without stepping.
        if (!bus.enable) begin
          state_next = IDLE;
        end else begin
          timer_run = 1'b1;
          if (step_due && !load_ok) begin
            step_fire = 1'b1;
            pos_next  = dir_reverse ? pos_dec : pos_inc;
            if (go) begin
              timer_latch = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (load_ok) begin
      pos_next = bus.load_position;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_reg  <= '0;
      a_reg    <= 1'b0;
      b_reg    <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      pos_reg        <= pos_next;
      {a_reg, b_reg} <= quad_map(pos_next[1:0]);
      tick_reg       <= step_fire;
    end
  end

`ifdef ENCODER_EMU_INDEX_EN
  logic index_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_reg <= 1'b1;
    end else begin
      index_reg <= (pos_next == '0);
    end
  end

  assign bus.index = index_reg;
`else
  assign bus.index = 1'b0;
`endif

  assign bus.encoder_a = a_reg;
  assign bus.encoder_b = b_reg;
  assign bus.position  = pos_reg;
  assign bus.tick      = tick_reg;

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Scoreboard bench: an edge-time model predicts every step; a monitor checks each tick.
module tb_quadrature_encoder_emulator;

  localparam int CPR  = 8192;
  localparam int MINP = 4;
  localparam logic [1:0] GRAY [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef struct {
    int cyc;
    int pos;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edge_count = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  // model state: position after the last edge, and the edge number of the next step
  int   m_pos = 0;
  bit   m_run = 1'b0;
  int   m_next = 0;
  int   m_per = MINP;
  bit   m_rev = 1'b0;

  quadrature_encoder_emulator_if #(.POS_W(13)) bus ();

  quadrature_encoder_emulator #(
    .COUNTS_PER_REV (CPR),
    .MIN_PERIOD     (MINP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_count);
    end
  endtask

  function automatic int exp_idx(input int p);
`ifdef ENCODER_EMU_INDEX_EN
    return (p == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int clamp_mag(input int tp);
    int m;
    m = (tp < 0) ? -tp : tp;
    return (m < MINP) ? MINP : m;
  endfunction

  function automatic bit due_next();
    return m_run && (m_next == edge_count + 2);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.tick === 1'b1) begin
      if (q.size() == 0) begin
        chk("tick_unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        chk("tick_edge", edge_count, e.cyc);
        chk("tick_pos", bus.position, e.pos);
        chk("tick_ab", {bus.encoder_a, bus.encoder_b}, GRAY[e.pos % 4]);
        chk("tick_idx", bus.index, exp_idx(e.pos));
      end
    end else if (q.size() > 0 && q[0].cyc <= edge_count) begin
      e = q.pop_front();
      chk("tick_missed", edge_count, e.cyc + 1000000);
    end
  end

  // Check outputs of the last edge, drive inputs for the next one, predict its effect.
  task automatic cyc(input bit en, input int tp, input bit ld, input int lp);
    int n;
    @(negedge clk);
    chk("pos", bus.position, m_pos);
    chk("ab", {bus.encoder_a, bus.encoder_b}, GRAY[m_pos % 4]);
    chk("idx", bus.index, exp_idx(m_pos));
    bus.enable        = en;
    bus.tick_period   = 16'(tp);
    bus.load          = ld;
    bus.load_position = 13'(lp);
    n = edge_count + 1;
    if (!m_run) begin
      if (en && tp != 0) begin
        m_run  = 1'b1;
        m_per  = clamp_mag(tp);
        m_rev  = (tp < 0);
        m_next = n + m_per;
      end
      if (ld) m_pos = lp;
    end else if (!en) begin
      m_run = 1'b0;
      if (ld) m_pos = lp;
    end else if (ld) begin
      m_pos  = lp;
      m_next = n + m_per;
    end else if (n == m_next) begin
      m_pos = m_rev ? (m_pos + CPR - 1) % CPR : (m_pos + 1) % CPR;
      q.push_back('{n, m_pos});
      if (tp == 0) begin
        m_run = 1'b0;
      end else begin
        m_per  = clamp_mag(tp);
        m_rev  = (tp < 0);
        m_next = n + m_per;
      end
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    bus.enable = 1'b0; bus.tick_period = '0; bus.load = 1'b0; bus.load_position = '0;
    reset = 1'b0;
    #1;
    chk("rst_tick_now", bus.tick, 0);
    chk("rst_pos_now", bus.position, 0);
    q.delete();
    m_pos = 0; m_run = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("rst_ab", {bus.encoder_a, bus.encoder_b}, 0);
      chk("rst_idx", bus.index, exp_idx(0));
      chk("rst_tick", bus.tick, 0);
    end
    #2;
    reset = 1'b1;
  endtask

  task automatic run_for(input int cycles, input int tp);
    for (int i = 0; i < cycles; i++) cyc(1'b1, tp, 1'b0, 0);
  endtask

  initial begin
    int tp;
    bit en, ld;
    int lp;
    bus.enable = 1'b0; bus.tick_period = '0; bus.load = 1'b0; bus.load_position = '0;

    do_reset(3);

    // forward at 10 clocks per count
    run_for(35, 10);
    // reverse from zero wraps to the top of the revolution
    do_reset(2);
    run_for(20, -6);
    // below the minimum period clamps up
    do_reset(2);
    run_for(25, 2);
    // period change mid-interval takes effect only after the current step
    run_for(8, 20);
    run_for(4, 20);
    run_for(30, 5);

    // load coincident with a step wins and suppresses the tick
    begin
      int guard = 0;
      while (!due_next() && guard < 50) begin
        cyc(1'b1, 8, 1'b0, 0);
        guard++;
      end
      chk("load_align_timeout", due_next(), 1);
      cyc(1'b1, 8, 1'b1, 100);
      run_for(20, 8);
    end

    // forward wrap from the last count
    cyc(1'b1, 4, 1'b1, CPR - 2);
    run_for(16, 4);

    // enable low mid-run holds outputs, then reset clears them
    run_for(3, 7);
    for (int i = 0; i < 12; i++) cyc(1'b0, 7, 1'b0, 0);
    do_reset(3);

    // random traffic
    tp = 6;
    for (int i = 0; i < 900; i++) begin
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 9) == 0) begin
        tp = $urandom_range(0, 26) - 13;
        if (tp == 0 && $urandom_range(0, 2) != 0) tp = 3;
      end
      ld = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 2))
        0:       lp = $urandom_range(0, 3);
        1:       lp = CPR - 1 - $urandom_range(0, 3);
        default: lp = $urandom_range(0, CPR - 1);
      endcase
      cyc(en, tp, ld, lp);
    end

    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b0, 0);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
